ft2232h_tx_fifo: RTL

//  Parametrised FT2232H sync-FIFO-mode transmit engine: buffers bytes from a valid/ready source in an

---
 rtl/ft2232h_tx_fifo.sv | 114 +++++++++++
 1 files changed

// File: rtl/ft2232h_tx_fifo.sv
// FT2232H sync-FIFO transmit engine: buffers source bytes and drives them onto WR#/D[7:0],
// re-presenting any byte refused by TXE#, with an optional SIWU# flush pulse after an idle gap.
module ft2232h_tx_fifo #(
  parameter int  DATA_W     = 8,
  parameter int  DEPTH      = 16,
  parameter int  IDLE_FLUSH = 0,
  parameter int  CNT_W      = 32,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              txe,
  output logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              siwu,
  output logic [PTR_W:0]    fill_level,
  output logic [CNT_W-1:0]  bytes_sent
);

  localparam int IDLE_W = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_PRESENT, ST_HELD} out_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  out_state_e        state_q;
  logic              wr_q, siwu_q, siwu_d, armed_q, armed_d;
  logic [DATA_W-1:0] dout_q;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              full, out_full, acc, push, load;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign s_ready  = ~full & ~reset;
  assign push     = s_valid & s_ready;
  assign out_full = (state_q != ST_EMPTY);
  assign acc      = ~wr_q & ~txe;
  // A held byte that was not taken blocks the load; the FIFO never bypasses to the pins.
  assign load     = (~out_full | acc) & (count_q != '0);

  assign wr         = wr_q;
  assign data_out   = dout_q;
  assign siwu       = siwu_q;
  assign fill_level = count_q;
  assign bytes_sent = bytes_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(load);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(load);
    bytes_d  = bytes_q + CNT_W'(acc);
    idle_d   = idle_q;
    armed_d  = armed_q;
    siwu_d   = 1'b1;
    // One flush per idle gap: armed by an accept, disarmed by the pulse or by new data.
    if (push) begin
      armed_d = 1'b0;
      idle_d  = '0;
    end else if (acc) begin
      armed_d = 1'b1;
      idle_d  = '0;
    end else if (IDLE_FLUSH > 0 && armed_q && !out_full && count_q == '0) begin
      idle_d = idle_q + IDLE_W'(1);
      if (idle_q == IDLE_W'(IDLE_FLUSH - 1)) begin
        siwu_d  = 1'b0;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
      wr_q     <= 1'b1;
      dout_q   <= '0;
      siwu_q   <= 1'b1;
      bytes_q  <= '0;
      idle_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      siwu_q   <= siwu_d;
      bytes_q  <= bytes_d;
      idle_q   <= idle_d;
      armed_q  <= armed_d;
      if (load) begin
        dout_q <= mem_q[rd_ptr_q];
      end
      if (load || (out_full && !acc)) begin
        state_q <= txe ? ST_HELD : ST_PRESENT;
        wr_q    <= txe;
      end else begin
        state_q <= ST_EMPTY;
        wr_q    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule
